// File: rtl/shmem_arbiter_if.sv
// shmem_arbiter_if: core shared-bus ports plus shmem macro port around the arbiter
interface shmem_arbiter_if #(
  parameter int N_REQ  = 7,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] sreq, swen, sack;
  logic [N_REQ*ADDR_W-1:0] saddr;
  logic [N_REQ*DATA_W-1:0] sdataw;
  logic [DATA_W-1:0] sdatar, mdataw, mdatar;
  logic [ADDR_W-1:0] maddr;
  logic men, mwen, busy;
  logic [IW-1:0] gnt_id;
  modport slave (
    input  sreq, swen, saddr, sdataw, mdatar,
    output sack, sdatar, men, mwen, maddr, mdataw, busy, gnt_id
  );
  modport master (
    output sreq, swen, saddr, sdataw, mdatar,
    input  sack, sdatar, men, mwen, maddr, mdataw, busy, gnt_id
  );
endinterface

// File: rtl/shmem_arbiter.sv
// shmem_arbiter: round-robin sharing of one shmem port between N_REQ cores
module shmem_arbiter #(
  parameter int N_REQ  = 7,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rstn,
  shmem_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(RD_LAT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state;
  logic [IW-1:0] ptr, pick;
  logic [CW-1:0] cnt;
  logic found;
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = 0; k < N_REQ; k++)
      if (!found && bus.sreq[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        pick = IW'((int'(ptr) + k) % N_REQ);
      end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      bus.sack <= '0;
      bus.men <= 1'b0;
      bus.mwen <= 1'b0;
      bus.maddr <= '0;
      bus.mdataw <= '0;
      bus.sdatar <= '0;
      bus.busy <= 1'b0;
      bus.gnt_id <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      bus.sack <= '0;
      case (state)
        IDLE: if (found) begin
          state <= ISSUE;
          bus.busy <= 1'b1;
          bus.gnt_id <= pick;
          ptr <= (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          bus.men <= 1'b1;
          bus.mwen <= bus.swen[pick];
          bus.maddr <= bus.saddr[pick*ADDR_W +: ADDR_W];
          bus.mdataw <= bus.sdataw[pick*DATA_W +: DATA_W];
        end
        ISSUE: begin
          bus.men <= 1'b0;
          bus.mwen <= 1'b0;
          bus.mdataw <= '0;
          cnt <= CW'(RD_LAT - 1);
          state <= bus.mwen ? ACK : WAIT;
          if (bus.mwen) bus.sack <= N_REQ'(1) << bus.gnt_id;
        end
        WAIT: if (cnt == '0) begin
          bus.sdatar <= bus.mdatar;
          bus.sack <= N_REQ'(1) << bus.gnt_id;
          state <= ACK;
        end else cnt <= cnt - 1'b1;
        ACK: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: doc/shmem_arbiter.md
Name: shmem_arbiter

Overview:
- Shares one shared-memory macro port (EN/WEN/ADDR/DATAR/DATAW) between N_REQ core shared-bus ports (SADDR/SDATAW/SWEN/SDATAR) using round-robin arbitration.
- Each core raises a request and holds its address, data and write-enable stable until it receives a one-cycle acknowledge.
- Sits between the core array and each shmem instance on a chiplet.

Parameters:
- N_REQ, 7, number of requesting cores (2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, shmem read latency: cycles from the MEN cycle to MDATAR valid (1..4)

Ports:
- CLK  input  1  clock, rising edge
- RSTN  input  1  asynchronous active-low reset
- SREQ  input  N_REQ  per-core request, level, held until SACK
- SWEN  input  N_REQ  per-core write enable (1=write), stable while SREQ
- SADDR  input  N_REQ*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
- SDATAW  input  N_REQ*DATA_W  packed write data, same packing
- SACK  output  N_REQ  one-hot, one-cycle completion pulse
- SDATAR  output  DATA_W  read data, broadcast, valid with SACK of a read
- MEN  output  1  shmem enable
- MWEN  output  1  shmem write enable
- MADDR  output  ADDR_W  shmem address
- MDATAW  output  DATA_W  shmem write data
- MDATAR  input  DATA_W  shmem read data
- BUSY  output  1  high whenever state != IDLE
- GNT_ID  output  clog2(N_REQ)  index of the current or last granted core

Behaviour:
- Reset (async, RSTN=0): state=IDLE. SACK=0, MEN=0, MWEN=0, MADDR=0, MDATAW=0, SDATAR=0, BUSY=0, GNT_ID=0, rr pointer=0, wait counter=0. Asserting reset mid-transaction aborts it immediately; no SACK is issued for the aborted transaction.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any SREQ is set, pick the first set bit searching from rr pointer upward with wrap (pointer, pointer+1, ..., N_REQ-1, 0, ...). Latch winner index into GNT_ID, and latch its SWEN, SADDR and SDATAW. Set rr pointer = winner+1, wrapping to 0 after N_REQ-1. Go to ISSUE. If no request, stay in IDLE.
- ISSUE (exactly 1 cycle): MEN=1; MWEN, MADDR and MDATAW driven from the latched values.
  - Write: go to ACK.
  - Read: load counter with RD_LAT-1 and go to WAIT.
- MEN, MWEN and MDATAW are 0 in every state other than ISSUE. MADDR holds its last value.
- WAIT: decrement the counter each cycle. When counter==0, register MDATAR into SDATAR and go to ACK. With RD_LAT=1, WAIT lasts one cycle, so MDATAR is sampled in the cycle after ISSUE.
- ACK (1 cycle): SACK[GNT_ID]=1, all other SACK bits 0. SDATAR holds the read data; it is unchanged after a write. Go to IDLE.
- Completion latency, measured from the IDLE cycle in which the request is sampled:
  - write: SACK at cycle +2
  - read: SACK at cycle +2+RD_LAT
- Per-transaction occupancy: write 3 cycles, read 3+RD_LAT cycles. The requester drops SREQ on the edge that ends its SACK cycle, so it is not re-sampled.
- SREQ dropped mid-transaction: the transaction still completes and SACK still pulses. Inputs are ignored after the IDLE latch.
- Requests arriving while BUSY wait; none are lost, since requests are level-held.
- A core requesting back-to-back yields to every other pending core before it is granted again.
- SDATAR persists until the next read completes.

Test Plan:
- Single write: core 2 SREQ=1, SWEN=1, SADDR=0x100, SDATAW=0xDEADBEEF. Expect MEN=MWEN=1, MADDR=0x100, MDATAW=0xDEADBEEF at cycle +1; SACK=0b0000100 at cycle +2; BUSY back to 0 at cycle +3.
- Single read, RD_LAT=1: model returns 0xCAFEF00D for 0x100. Core 5 read 0x100 gives MEN=1, MWEN=0 at +1; SACK[5]=1 and SDATAR=0xCAFEF00D at +3.
- Round-robin: all 7 cores request continuously, re-requesting after each SACK. Expect grant order 0,1,2,3,4,5,6,0; no core receives two SACKs within any 7-grant window.
- Wrap and skip: after a grant to core 6, only cores 1 and 4 request. Expect core 1 then core 4.
- Reset mid-read: assert RSTN=0 during WAIT. Expect MEN, SACK, BUSY and SDATAR at 0 immediately. After release, the same pending request is served normally starting from rr pointer 0.
- RD_LAT=3 parameter sweep: read SACK appears at cycle +5; MEN is high for exactly 1 cycle; the value MDATAR presents at MEN+3 is returned.
